// File: rtl/led_pwm_controller.sv
// Memory-mapped LED peripheral: per-channel enable, PWM duty and blink gating.
// Define LED_BLINK_EN to build the BLINK/BPER registers and the blink phase generator.
module led_pwm_controller #(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESCALE = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                we,
    input  logic [1:0]          reg_sel,
    input  logic [15:0]         in,
    output logic [15:0]         out,
    output logic [NUM_LEDS-1:0] led
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic                wr_en;
    logic                wr_duty;
    logic [NUM_LEDS-1:0] en_q;
    logic [PWM_BITS-1:0] duty [NUM_LEDS];
    logic [PS_W-1:0]     prescaler;
    logic                step;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_wrap;
    logic [NUM_LEDS-1:0] pwm_on;
    logic [NUM_LEDS-1:0] blink_q;
    logic [15:0]         bper_q;
    logic                blink_phase;
    logic                unused_in;

    assign unused_in = ^in;
    assign wr_en     = cs && we && (reg_sel == 2'd0);
    assign wr_duty   = cs && we && (reg_sel == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q <= '0;
        end else if (wr_en) begin
            en_q <= in[NUM_LEDS-1:0];
        end
    end

    // Matching against each legal channel number drops out-of-range indexes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                duty[i] <= '1;
            end
        end else if (wr_duty) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (in[11:8] == 4'(i)) begin
                    duty[i] <= in[PWM_BITS-1:0];
                end
            end
        end
    end

    assign step     = (prescaler == PS_W'(PRESCALE - 1));
    assign pwm_wrap = step && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else begin
            prescaler <= step ? '0 : prescaler + PS_W'(1);
            if (step) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
        end
    end

    always_comb begin
        pwm_on = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            pwm_on[i] = (duty[i] == '1) || (pwm_cnt < duty[i]);
        end
    end

`ifdef LED_BLINK_EN
    logic        wr_blink;
    logic        wr_bper;
    logic [15:0] blink_cnt;

    assign wr_blink = cs && we && (reg_sel == 2'd1);
    assign wr_bper  = cs && we && (reg_sel == 2'd3);

    // A BPER write restarts the half-period count, so a shorter period never overruns.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q     <= '0;
            bper_q      <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            if (wr_blink) begin
                blink_q <= in[NUM_LEDS-1:0];
            end
            if (wr_bper) begin
                bper_q    <= in;
                blink_cnt <= '0;
            end else if (pwm_wrap) begin
                if (blink_cnt == bper_q) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign blink_q     = '0;
    assign bper_q      = '0;
    assign blink_phase = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= en_q & pwm_on & (~blink_q | {NUM_LEDS{blink_phase}});
        end
    end

    always_comb begin
        out = '0;
        if (cs) begin
            case (reg_sel)
                2'd0: out[NUM_LEDS-1:0] = en_q;
                2'd1: out[NUM_LEDS-1:0] = blink_q;
                2'd2: begin
                    out[15]           = blink_phase;
                    out[NUM_LEDS-1:0] = led;
                end
                default: out = bper_q;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pwm_controller.sv
// Directed bench for led_pwm_controller: one instance at PRESCALE=1, one at PRESCALE=4,
// sharing the bus; blink expectations follow LED_BLINK_EN.
module tb_led_pwm_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        we;
    logic [1:0]  reg_sel;
    logic [15:0] in;
    logic [15:0] out1;
    logic [15:0] out2;
    logic [7:0]  led1;
    logic [7:0]  led2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pwm_controller #(.NUM_LEDS(8), .PWM_BITS(4), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .reg_sel(reg_sel),
        .in(in), .out(out1), .led(led1)
    );

    led_pwm_controller #(.NUM_LEDS(8), .PWM_BITS(4), .PRESCALE(4)) dut2 (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .reg_sel(reg_sel),
        .in(in), .out(out2), .led(led2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] r, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; reg_sel = r; in = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; in = '0;
    endtask

    task automatic rd(input logic [1:0] r, output logic [15:0] v);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; reg_sel = r;
        #1 v = out1;
        cs = 1'b0;
    endtask

    task automatic cnt(input bit use2, input int ch, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            c += use2 ? int'(led2[ch]) : int'(led1[ch]);
        end
    endtask

    logic [15:0] v;
    int          c;

    initial begin
        reset = 1'b1; cs = 1'b0; we = 1'b0; reg_sel = 2'd0; in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("reset_led", 32'(led1), 32'h00);
        rd(2'd0, v); chk("reset_en", 32'(v), 32'h0000);
        rd(2'd2, v); chk("reset_reg2", 32'(v), 32'h8000);

        // 1: enable all, full duty after reset
        wr(2'd0, 16'h00FF);
        chk("en_latency", 32'(led1), 32'h00);
        @(negedge clk);
        chk("en_all_on", 32'(led1), 32'hFF);
        rd(2'd0, v); chk("en_read", 32'(v), 32'h00FF);

        // 2: duty 4, 0, 15 on channel 3
        wr(2'd2, 16'h0304);
        wr(2'd0, 16'h0008);
        repeat (2) @(negedge clk);
        cnt(1'b0, 3, 16, c); chk("duty4_cnt", 32'(c), 32'd4);
        cnt(1'b0, 0, 16, c); chk("ch0_disabled", 32'(c), 32'd0);
        wr(2'd2, 16'h0300);
        repeat (2) @(negedge clk);
        cnt(1'b0, 3, 16, c); chk("duty0_cnt", 32'(c), 32'd0);
        wr(2'd2, 16'h030F);
        repeat (2) @(negedge clk);
        cnt(1'b0, 3, 16, c); chk("duty15_cnt", 32'(c), 32'd16);

        // 3: out-of-range channel index is ignored
        wr(2'd0, 16'h00FF);
        wr(2'd2, 16'h0905);
        repeat (2) @(negedge clk);
        cnt(1'b0, 1, 16, c); chk("idx9_ch1_cnt", 32'(c), 32'd16);
        rd(2'd2, v);
`ifdef LED_BLINK_EN
        chk("idx9_reg2", 32'(v & 16'h7FFF), 32'h00FF);
`else
        chk("idx9_reg2", 32'(v), 32'h80FF);
`endif

        // 4: blink on channel 0, half-period 2 PWM periods
        wr(2'd1, 16'h0001);
        wr(2'd3, 16'h0001);
        wr(2'd0, 16'h0001);
        repeat (40) @(negedge clk);
        cnt(1'b0, 0, 64, c);
`ifdef LED_BLINK_EN
        chk("blink_cnt64", 32'(c), 32'd32);
        rd(2'd1, v); chk("blink_read", 32'(v), 32'h0001);
        rd(2'd3, v); chk("bper_read", 32'(v), 32'h0001);
`else
        chk("blink_cnt64", 32'(c), 32'd64);
        rd(2'd1, v); chk("blink_read", 32'(v), 32'h0000);
        rd(2'd3, v); chk("bper_read", 32'(v), 32'h0000);
`endif

        // 5: prescaled PWM, and bus activity with cs low
        wr(2'd1, 16'h0000);
        wr(2'd0, 16'h0008);
        wr(2'd2, 16'h0308);
        repeat (4) @(negedge clk);
        cnt(1'b1, 3, 64, c); chk("ps4_duty8_cnt", 32'(c), 32'd32);
        cnt(1'b0, 3, 16, c); chk("ps1_duty8_cnt", 32'(c), 32'd8);
        @(negedge clk);
        cs = 1'b0; we = 1'b1; reg_sel = 2'd0; in = 16'h0000;
        #1 chk("cs0_out1", 32'(out1), 32'h0000);
        chk("cs0_out2", 32'(out2), 32'h0000);
        @(negedge clk);
        we = 1'b0;
        rd(2'd0, v); chk("cs0_en_kept", 32'(v), 32'h0008);

        // 6: reset mid-blink, with a simultaneous EN write
        wr(2'd1, 16'h00FF);
        wr(2'd3, 16'h0003);
        wr(2'd0, 16'h00FF);
        repeat (20) @(negedge clk);
        reset = 1'b1; cs = 1'b1; we = 1'b1; reg_sel = 2'd0; in = 16'h00FF;
        @(negedge clk);
        chk("rst_led1", 32'(led1), 32'h00);
        chk("rst_led2", 32'(led2), 32'h00);
        chk("rst_en", 32'(out1), 32'h0000);
        reset = 1'b0; cs = 1'b0; we = 1'b0; in = '0;
        rd(2'd3, v); chk("rst_bper", 32'(v), 32'h0000);
        rd(2'd2, v); chk("rst_reg2", 32'(v), 32'h8000);
        rd(2'd1, v); chk("rst_blink", 32'(v), 32'h0000);
        wr(2'd0, 16'h0008);
        repeat (2) @(negedge clk);
        cnt(1'b0, 3, 16, c); chk("rst_duty_full", 32'(c), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
